// File: rtl/scene_sequencer_pkg.sv
// Shared types and screen constants for the scene sequencer and its bus.
package scene_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Field widths derived from the 160x120 raster and the 3-bit RGB colour.
  localparam int X_W      = $clog2(SCREEN_W);
  localparam int Y_W      = $clog2(SCREEN_H);
  localparam int COLOUR_W = 3;
  localparam int RADIUS_W = 8;
  localparam int INDEX_W  = 4;

  // Scene FSM states; explicit encodings keep the values stable for debug.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_CLEAR_REL = 3'd2,
    ST_DRAW      = 3'd3,
    ST_DRAW_REL  = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // Radius of circle idx: base + idx*step, saturated at the 8-bit maximum.
  // The sum is formed wide enough that any legal step cannot wrap before
  // the clamp is applied.
  function automatic logic [RADIUS_W-1:0] clamp_radius(
    input logic [RADIUS_W-1:0] base,
    input logic [INDEX_W-1:0]  idx,
    input logic [RADIUS_W-1:0] step
  );
    logic [12:0] sum;
    sum = 13'(base) + 13'(idx) * 13'(step);
    return (sum > 13'd255) ? 8'hFF : sum[RADIUS_W-1:0];
  endfunction

endpackage

// File: rtl/scene_sequencer_if.sv
// Bundle of the host handshake, both engine ports and the VGA plot port.
interface scene_sequencer_if;
  import scene_pkg::*;

  // Host side
  logic                start;
  logic [X_W-1:0]      centre_x;
  logic [Y_W-1:0]      centre_y;
  logic [RADIUS_W-1:0] base_radius;
  logic [COLOUR_W-1:0] base_colour;
  logic                done;
  logic                busy;

  // Fillscreen engine
  logic                fs_start;
  logic [COLOUR_W-1:0] fs_colour;
  logic                fs_done;
  logic [X_W-1:0]      fs_x;
  logic [Y_W-1:0]      fs_y;
  logic [COLOUR_W-1:0] fs_colour_o;
  logic                fs_plot;

  // Circle engine
  logic                circ_start;
  logic [X_W-1:0]      circ_centre_x;
  logic [Y_W-1:0]      circ_centre_y;
  logic [RADIUS_W-1:0] circ_radius;
  logic [COLOUR_W-1:0] circ_colour;
  logic                circ_done;
  logic [X_W-1:0]      circ_x;
  logic [Y_W-1:0]      circ_y;
  logic [COLOUR_W-1:0] circ_colour_o;
  logic                circ_plot;

  // VGA adapter plot port
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  // Sequencer view
  modport master (
    input  start, centre_x, centre_y, base_radius, base_colour,
    output done, busy,
    output fs_start, fs_colour,
    input  fs_done, fs_x, fs_y, fs_colour_o, fs_plot,
    output circ_start, circ_centre_x, circ_centre_y, circ_radius, circ_colour,
    input  circ_done, circ_x, circ_y, circ_colour_o, circ_plot,
    output vga_x, vga_y, vga_colour, vga_plot
  );

  // Environment view: host, engines and VGA adapter
  modport slave (
    output start, centre_x, centre_y, base_radius, base_colour,
    input  done, busy,
    input  fs_start, fs_colour,
    output fs_done, fs_x, fs_y, fs_colour_o, fs_plot,
    input  circ_start, circ_centre_x, circ_centre_y, circ_radius, circ_colour,
    output circ_done, circ_x, circ_y, circ_colour_o, circ_plot,
    input  vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/scene_sequencer.sv
// Scene controller: clear the screen, then draw N_CIRCLES concentric circles
// with stepped radius and rotating colour, muxing the active engine onto VGA.
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int unsigned         N_CIRCLES   = 4,
  parameter int unsigned         RADIUS_STEP = 10,
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000
) (
  input logic               clk,
  input logic               rst,
  scene_sequencer_if.master bus
);

  localparam logic [INDEX_W:0]    LP_N_CIRCLES = (INDEX_W+1)'(N_CIRCLES);
  localparam logic [RADIUS_W-1:0] LP_STEP      = RADIUS_W'(RADIUS_STEP);
  localparam logic                LP_HAS_CIRC  = (N_CIRCLES > 0);

  state_t              r_state;
  state_t              w_next_state;
  logic [INDEX_W-1:0]  r_index;
  logic [X_W-1:0]      r_centre_x;
  logic [Y_W-1:0]      r_centre_y;
  logic [RADIUS_W-1:0] r_base_radius;
  logic [COLOUR_W-1:0] r_base_colour;

  logic                w_accept;
  logic                w_last_circle;

  assign w_accept      = (r_state == ST_IDLE) && bus.start;
  assign w_last_circle = ({1'b0, r_index} + 1'b1) >= LP_N_CIRCLES;

  // Next-state logic for the clear/draw sequence.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:      if (bus.start)     w_next_state = ST_CLEAR;
      ST_CLEAR:     if (bus.fs_done)   w_next_state = ST_CLEAR_REL;
      ST_CLEAR_REL: w_next_state = LP_HAS_CIRC ? ST_DRAW : ST_DONE;
      ST_DRAW:      if (bus.circ_done) w_next_state = ST_DRAW_REL;
      ST_DRAW_REL:  w_next_state = w_last_circle ? ST_DONE : ST_DRAW;
      ST_DONE:      if (!bus.start)    w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // State, circle index and the scene parameters captured on acceptance.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_index       <= '0;
      r_centre_x    <= '0;
      r_centre_y    <= '0;
      r_base_radius <= '0;
      r_base_colour <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_index       <= '0;
        r_centre_x    <= bus.centre_x;
        r_centre_y    <= bus.centre_y;
        r_base_radius <= bus.base_radius;
        r_base_colour <= bus.base_colour;
      end else if (r_state == ST_DRAW_REL) begin
        r_index <= r_index + 1'b1;
      end
    end
  end

  // Handshake levels are pure state decodes, so both starts drop in the
  // cycle after reset and each release state gives exactly one low cycle.
  assign bus.fs_start   = (r_state == ST_CLEAR);
  assign bus.circ_start = (r_state == ST_DRAW);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign bus.fs_colour  = BG_COLOUR;

  // Per-circle parameters; the colour wraps naturally in its 3-bit width.
  assign bus.circ_centre_x = r_centre_x;
  assign bus.circ_centre_y = r_centre_y;
  assign bus.circ_radius   = clamp_radius(r_base_radius, r_index, LP_STEP);
  assign bus.circ_colour   = r_base_colour + COLOUR_W'(r_index);

  // Zero-latency plot mux: only the engine owning the screen reaches VGA.
  always_comb begin
    bus.vga_x      = '0;
    bus.vga_y      = '0;
    bus.vga_colour = '0;
    bus.vga_plot   = 1'b0;
    unique case (r_state)
      ST_CLEAR: begin
        bus.vga_x      = bus.fs_x;
        bus.vga_y      = bus.fs_y;
        bus.vga_colour = bus.fs_colour_o;
        bus.vga_plot   = bus.fs_plot;
      end
      ST_DRAW: begin
        bus.vga_x      = bus.circ_x;
        bus.vga_y      = bus.circ_y;
        bus.vga_colour = bus.circ_colour_o;
        bus.vga_plot   = bus.circ_plot;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Scoreboard bench for scene_sequencer with behavioural engine stubs.
module tb_scene_sequencer;
  import scene_pkg::*;

  localparam int N_CIRC   = 4;
  localparam int STEP     = 10;
  localparam int FS_LAT   = 6;
  localparam int CIRC_LAT = 4;

  typedef struct packed {
    logic [7:0] cx;
    logic [6:0] cy;
    logic [7:0] r;
    logic [2:0] col;
  } circ_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scene_sequencer_if bus ();
  scene_sequencer_if bus0 ();

  scene_sequencer #(.N_CIRCLES(N_CIRC), .RADIUS_STEP(STEP), .BG_COLOUR(3'b000)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  scene_sequencer #(.N_CIRCLES(0), .RADIUS_STEP(STEP), .BG_COLOUR(3'b000)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  int    n_pass = 0;
  int    n_total = 0;
  circ_t exp_q[$];
  int    fs_runs, circ_runs;
  bit    mon_en = 0;
  bit    circ0_ever = 0;
  int    fs_cnt, circ_cnt, fs0_cnt;

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fillscreen stub for the main DUT: done after FS_LAT cycles of start.
  always_ff @(posedge clk) begin
    bus.fs_x        <= 8'($urandom);
    bus.fs_y        <= 7'($urandom);
    bus.fs_colour_o <= 3'($urandom);
    bus.fs_plot     <= rst ? 1'b0 : ~bus.fs_plot;
    if (rst || !bus.fs_start) begin
      fs_cnt      <= 0;
      bus.fs_done <= 1'b0;
    end else begin
      if (fs_cnt < FS_LAT) fs_cnt <= fs_cnt + 1;
      bus.fs_done <= (fs_cnt + 1 >= FS_LAT);
    end
  end

  // Circle stub for the main DUT: done after CIRC_LAT cycles of start.
  always_ff @(posedge clk) begin
    bus.circ_x        <= 8'($urandom);
    bus.circ_y        <= 7'($urandom);
    bus.circ_colour_o <= 3'($urandom);
    bus.circ_plot     <= rst ? 1'b0 : ~bus.circ_plot;
    if (rst || !bus.circ_start) begin
      circ_cnt      <= 0;
      bus.circ_done <= 1'b0;
    end else begin
      if (circ_cnt < CIRC_LAT) circ_cnt <= circ_cnt + 1;
      bus.circ_done <= (circ_cnt + 1 >= CIRC_LAT);
    end
  end

  // Fillscreen stub for the zero-circle DUT; its circle port stays idle.
  always_ff @(posedge clk) begin
    bus0.fs_x        <= 8'($urandom);
    bus0.fs_y        <= 7'($urandom);
    bus0.fs_colour_o <= 3'($urandom);
    bus0.fs_plot     <= rst ? 1'b0 : ~bus0.fs_plot;
    if (rst || !bus0.fs_start) begin
      fs0_cnt      <= 0;
      bus0.fs_done <= 1'b0;
    end else begin
      if (fs0_cnt < FS_LAT) fs0_cnt <= fs0_cnt + 1;
      bus0.fs_done <= (fs0_cnt + 1 >= FS_LAT);
    end
  end
  assign bus0.circ_done     = 1'b0;
  assign bus0.circ_x        = '0;
  assign bus0.circ_y        = '0;
  assign bus0.circ_colour_o = '0;
  assign bus0.circ_plot     = 1'b0;

  // Monitor: mux, handshake spacing and scoreboard pops on each circle start.
  initial begin
    logic        prev_fs = 1'b0, prev_circ = 1'b0;
    int          idle_cnt = 0;
    logic [18:0] exp_vga, act_vga;
    circ_t       e, a;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_vga = '0;
        if (bus.fs_start)
          exp_vga = {bus.fs_x, bus.fs_y, bus.fs_colour_o, bus.fs_plot};
        else if (bus.circ_start)
          exp_vga = {bus.circ_x, bus.circ_y, bus.circ_colour_o, bus.circ_plot};
        act_vga = {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot};
        check("vga_mux", act_vga === exp_vga && !(bus.fs_start && bus.circ_start),
              32'(act_vga), 32'(exp_vga));

        if (bus.fs_start && !prev_fs) fs_runs++;
        if (bus.circ_start && !prev_circ) begin
          check("circ_gap", idle_cnt == 1, 32'(idle_cnt), 32'd1);
          check("circ_vs_fs", bus.fs_start === 1'b0, 32'(bus.fs_start), 32'd0);
          a = '{cx: bus.circ_centre_x, cy: bus.circ_centre_y,
                r: bus.circ_radius, col: bus.circ_colour};
          if (exp_q.size() == 0) begin
            check("sb_underflow", 1'b0, 32'(a), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("circ_params", a === e, 32'(a), 32'(e));
          end
          circ_runs++;
        end
        if (rst) idle_cnt = 0;
        else if (bus.busy && !bus.fs_start && !bus.circ_start) idle_cnt++;
        else idle_cnt = 0;
        if (bus0.circ_start) circ0_ever = 1'b1;
      end
      prev_fs   = bus.fs_start;
      prev_circ = bus.circ_start;
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctrl"},
          {bus.done, bus.busy, bus.fs_start, bus.circ_start, bus.vga_plot} === 5'b0,
          32'({bus.done, bus.busy, bus.fs_start, bus.circ_start, bus.vga_plot}), 32'd0);
    check({tag, "_data"},
          {bus.vga_x, bus.vga_y, bus.vga_colour, bus.circ_radius, bus.circ_colour} === 29'b0,
          32'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.circ_radius, bus.circ_colour}), 32'd0);
    check({tag, "_centre"}, {bus.circ_centre_x, bus.circ_centre_y} === 15'b0,
          32'({bus.circ_centre_x, bus.circ_centre_y}), 32'd0);
  endtask

  // One complete scene; the expected circles come from the radius/colour rules.
  task automatic run_scene(input logic [7:0] cx, input logic [6:0] cy,
                           input logic [7:0] br, input logic [2:0] bc, input bit drop_early);
    circ_t e;
    int    r;
    bit    ok;
    int    hold;
    fs_runs   = 0;
    circ_runs = 0;
    for (int i = 0; i < N_CIRC; i++) begin
      r = int'(br) + i * STEP;
      if (r > 255) r = 255;
      e.cx  = cx;
      e.cy  = cy;
      e.r   = 8'(r);
      e.col = 3'((int'(bc) + i) % 8);
      exp_q.push_back(e);
    end
    bus.start       = 1'b1;
    bus.centre_x    = cx;
    bus.centre_y    = cy;
    bus.base_radius = br;
    bus.base_colour = bc;
    tick();
    check("accept", bus.busy === 1'b1 && bus.fs_start === 1'b1,
          32'({bus.busy, bus.fs_start}), 32'b11);
    bus.centre_x    = 8'($urandom);
    bus.centre_y    = 7'($urandom);
    bus.base_radius = 8'($urandom);
    bus.base_colour = 3'($urandom);
    if (drop_early) bus.start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (bus.done === 1'b1) begin ok = 1'b1; break; end
    end
    check("done_seen", ok, 32'(ok), 32'd1);
    check("fill_runs", fs_runs == 1, 32'(fs_runs), 32'd1);
    check("circle_runs", circ_runs == N_CIRC, 32'(circ_runs), 32'(N_CIRC));
    check("sb_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
    if (drop_early) begin
      tick();
      check("done_pulse", bus.done === 1'b0 && bus.busy === 1'b0,
            32'({bus.done, bus.busy}), 32'd0);
    end else begin
      hold = $urandom_range(1, 4);
      repeat (hold) begin
        tick();
        check("done_hold", bus.done === 1'b1, 32'(bus.done), 32'd1);
      end
      bus.start = 1'b0;
      tick();
      check("done_release", bus.done === 1'b0 && bus.busy === 1'b0,
            32'({bus.done, bus.busy}), 32'd0);
    end
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Stimulus: directed scenes, mid-draw reset, random scenes, zero-circle DUT.
  initial begin
    bit ok;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.centre_x     = '0;
    bus.centre_y     = '0;
    bus.base_radius  = '0;
    bus.base_colour  = '0;
    bus0.start       = 1'b0;
    bus0.centre_x    = '0;
    bus0.centre_y    = '0;
    bus0.base_radius = '0;
    bus0.base_colour = '0;
    repeat (3) tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    run_scene(8'd80, 7'd60, 8'd40, 3'b011, 1'b0);
    run_scene(8'd80, 7'd60, 8'd240, 3'b111, 1'b0);

    // Reset while a circle is being drawn
    fs_runs = 0;
    circ_runs = 0;
    bus.start       = 1'b1;
    bus.centre_x    = 8'd10;
    bus.centre_y    = 7'd20;
    bus.base_radius = 8'd5;
    bus.base_colour = 3'd2;
    for (int i = 0; i < N_CIRC; i++)
      exp_q.push_back('{cx: 8'd10, cy: 7'd20, r: 8'(5 + i * STEP), col: 3'(2 + i)});
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (bus.circ_start === 1'b1) begin ok = 1'b1; break; end
    end
    check("reach_draw", ok, 32'(ok), 32'd1);
    tick();
    rst = 1'b1;
    bus.start = 1'b0;
    tick();
    tick();
    exp_q.delete();
    check_zero_outputs("mid_reset");
    rst = 1'b0;
    tick();
    run_scene(8'd3, 7'd119, 8'd0, 3'd0, 1'b0);

    for (int s = 0; s < 12; s++)
      run_scene(8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)),
                8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));

    // Zero-circle scene with start dropped during the fill
    bus0.start = 1'b1;
    tick();
    check("n0_accept", bus0.busy === 1'b1 && bus0.fs_start === 1'b1,
          32'({bus0.busy, bus0.fs_start}), 32'b11);
    bus0.start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (bus0.done === 1'b1) begin ok = 1'b1; break; end
    end
    check("n0_done_seen", ok, 32'(ok), 32'd1);
    check("n0_done_vga", bus0.vga_plot === 1'b0 && bus0.circ_start === 1'b0,
          32'({bus0.vga_plot, bus0.circ_start}), 32'd0);
    tick();
    check("n0_done_pulse", bus0.done === 1'b0 && bus0.busy === 1'b0,
          32'({bus0.done, bus0.busy}), 32'd0);
    check("n0_no_circ", circ0_ever == 1'b0, 32'(circ0_ever), 32'd0);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
